// File: rtl/srl_fifo_pkg.sv
// Shared constants and helpers for the 16-entry shift-register FIFO.
// Optional error flags are enabled with the SRL_FIFO_ERR_EN macro.
package srl_fifo_pkg;

    localparam int SRL_FIFO_DEPTH = 16;
    localparam int SRL_FIFO_PTR_W = 4;
    localparam int SRL_FIFO_CNT_W = 5;
    localparam int SRL_FIFO_HALF  = 8;

    typedef logic [SRL_FIFO_CNT_W-1:0] srl_cnt_t;
    typedef logic [SRL_FIFO_PTR_W-1:0] srl_ptr_t;

    // The oldest word sits at position count-1. For count == 16 the low four
    // bits are 0, so the wrap to 15 is exactly what we want. The value for
    // count == 0 is meaningless and is masked by the caller.
    function automatic srl_ptr_t srl_rd_addr(input srl_cnt_t cnt);
        return cnt[SRL_FIFO_PTR_W-1:0] - srl_ptr_t'(1);
    endfunction

endpackage

// File: rtl/srl_fifo_store.sv
// 16-deep, WIDTH-wide shift array with enable and a 4-bit addressed read.
// Behaves like one SRL16 per data bit: new data enters at position 0, older
// words move up one place, and the read tap is a plain mux on the array.
// Storage is intentionally not reset so it maps onto SRL primitives.
module srl_fifo_store
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    input  srl_ptr_t         addr_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] data_q [SRL_FIFO_DEPTH];

    // Shift the whole array by one on an accepted write.
    always_ff @(posedge CLK) begin
        if (en_i) begin
            data_q[0] <= din_i;
            for (int i = 1; i < SRL_FIFO_DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign dout_o = data_q[addr_i];

endmodule

// File: rtl/srl_fifo16.sv
// 16-entry synchronous FIFO on shift-register storage. Writes shift into the
// store; an occupancy count addresses the oldest word, so reads never move
// data. Flags decode straight from the count register.
// Define SRL_FIFO_ERR_EN to add sticky OVERFLOW/UNDERFLOW outputs.
module srl_fifo16
    import srl_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             WRITE,
    input  logic             READ,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             HALF_FULL,
    output logic             FULL
`ifdef SRL_FIFO_ERR_EN
    ,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
`endif
);

    srl_cnt_t         count_q;
    srl_cnt_t         count_d;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] store_dout;

    // Flags come only from the count register, never from the strobes.
    assign EMPTY     = (count_q == '0);
    assign FULL      = (count_q == srl_cnt_t'(SRL_FIFO_DEPTH));
    assign HALF_FULL = (count_q >= srl_cnt_t'(SRL_FIFO_HALF));

    // A write into a full FIFO is dropped even if a read frees a slot in the
    // same cycle; a read from an empty FIFO is dropped even if a write lands.
    assign wr_acc = WRITE && !FULL;
    assign rd_acc = READ && !EMPTY;

    // Simultaneous write and read: shift plus unchanged address keeps order.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + srl_cnt_t'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - srl_cnt_t'(1);
        end
    end

    // Occupancy register; reset empties the FIFO immediately.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    srl_fifo_store #(
        .WIDTH (WIDTH)
    ) u_store (
        .CLK    (CLK),
        .en_i   (wr_acc),
        .din_i  (DIN),
        .addr_i (srl_rd_addr(count_q)),
        .dout_o (store_dout)
    );

    // Stale storage contents are hidden while empty.
    assign DOUT = EMPTY ? '0 : store_dout;

`ifdef SRL_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (WRITE && !wr_acc) overflow_q  <= 1'b1;
            if (READ && EMPTY)    underflow_q <= 1'b1;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign UNDERFLOW = underflow_q;
`endif

endmodule
